// File: rtl/roubus_req_feeder.sv
// Store-and-forward feeder: buffers one packet, waits for room in the noc3 request queue, then pushes it back-to-back.
// Optional statistics counters are enabled with `define ROUBUS_FEEDER_STATS_EN.
module roubus_req_feeder #(
    parameter int QDEPTH   = 64,
    parameter int BUFDEPTH = 16,
    parameter int DW       = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_queue,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic [2:0]    req_addr,
    output logic [DW-1:0] req_data,
    output logic          req_write,
    input  logic [7:0]    req_count,
    output logic          pkt_sent,
    output logic          err_trunc,
    output logic          busy
`ifdef ROUBUS_FEEDER_STATS_EN
    ,
    output logic [31:0]   pkt_total,
    output logic [31:0]   stall_cycles
`endif
);
    localparam int AW = $clog2(BUFDEPTH);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(BUFDEPTH);

    typedef enum logic [2:0] {COLLECT, DROP, SETTLE, CHECK, PUSH} state_t;

    state_t        state;
    logic [DW-1:0] pkt_buf [BUFDEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   len;
    logic [8:0]    free;
    logic          accept;
    logic          room;

    assign in_ready = !rst && (state == COLLECT || state == DROP);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != COLLECT) || (len != '0);

    // An over-reported occupancy (req_count > QDEPTH) must never look like free space.
    always_comb begin
        free = 9'(QDEPTH) - {1'b0, req_count};
        if ({1'b0, req_count} > 9'(QDEPTH)) begin
            free = '0;
        end
    end

    assign room = free >= 9'(len);

    always_ff @(posedge clk) begin
        if (accept && state == COLLECT) begin
            pkt_buf[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            len       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            req_write <= 1'b0;
            pkt_sent  <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        wptr <= wptr + 1'b1;
                        len  <= len + 1'b1;
                        if (len == '0) begin
                            req_addr <= in_queue;
                        end
                        if (in_last) begin
                            state <= SETTLE;
                        end else if (len + 1'b1 == LEN_MAX) begin
                            // Keep the full buffer as the packet and swallow the rest.
                            err_trunc <= 1'b1;
                            state     <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (accept && in_last) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: state <= CHECK;
                CHECK: begin
                    if (room) begin
                        state     <= PUSH;
                        req_write <= 1'b1;
                        req_data  <= pkt_buf[rptr];
                        rptr      <= rptr + 1'b1;
                        pkt_sent  <= (rptr == AW'(len - 1'b1));
                    end
                end
                PUSH: begin
                    // pkt_sent marks the word currently on req_data as the final one.
                    if (pkt_sent) begin
                        state     <= COLLECT;
                        req_write <= 1'b0;
                        pkt_sent  <= 1'b0;
                        len       <= '0;
                        wptr      <= '0;
                        rptr      <= '0;
                    end else begin
                        req_data <= pkt_buf[rptr];
                        rptr     <= rptr + 1'b1;
                        pkt_sent <= (rptr == AW'(len - 1'b1));
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef ROUBUS_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_total    <= '0;
            stall_cycles <= '0;
        end else begin
            if (pkt_sent) begin
                pkt_total <= pkt_total + 32'd1;
            end
            if (state == CHECK && !room) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_roubus_req_feeder.sv
// Self-checking bench for roubus_req_feeder: randomized packets against a packet-level reference model.
module tb_roubus_req_feeder;
    localparam int QDEPTH   = 64;
    localparam int BUFDEPTH = 16;
    localparam int DW       = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_queue;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [2:0]    req_addr;
    logic [DW-1:0] req_data;
    logic          req_write;
    logic [7:0]    req_count;
    logic          pkt_sent;
    logic          err_trunc;
    logic          busy;
`ifdef ROUBUS_FEEDER_STATS_EN
    logic [31:0]   pkt_total;
    logic [31:0]   stall_cycles;
`endif

    typedef struct {
        logic [2:0]    addr;
        logic [DW-1:0] data;
        logic          sent;
        int            cyc;
    } push_t;

    logic [7:0]    occ [8];
    logic [DW-1:0] beats [$];
    push_t         obs_q [$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;

    // noc3 reports the occupancy of whichever queue req_addr selects.
    assign req_count = occ[req_addr];

    roubus_req_feeder #(.QDEPTH(QDEPTH), .BUFDEPTH(BUFDEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_queue(in_queue), .in_data(in_data), .in_last(in_last),
        .req_addr(req_addr), .req_data(req_data), .req_write(req_write),
        .req_count(req_count), .pkt_sent(pkt_sent), .err_trunc(err_trunc), .busy(busy)
`ifdef ROUBUS_FEEDER_STATS_EN
        , .pkt_total(pkt_total), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req_write) obs_q.push_back('{req_addr, req_data, pkt_sent, cyc});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic make_beats(input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    endtask

    // Drives all of beats[] as one packet; returns the cycle in which the final beat transferred.
    task automatic send_packet(input logic [2:0] q, input int gaps, output int last_acc);
        int waitc;
        last_acc = 0;
        for (int i = 0; i < beats.size(); i++) begin
            if (gaps != 0 && $urandom_range(0, 1) == 1) @(negedge clk);
            in_valid = 1'b1;
            in_queue = (i == 0) ? q : 3'($urandom);
            in_data  = beats[i];
            in_last  = (i == beats.size() - 1);
            #1;
            waitc = 0;
            while (!in_ready && waitc < 300) begin
                @(negedge clk); #1; waitc++;
            end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL beat_accept: beat %0d not accepted within 300 cycles, required in_ready=1", i);
            end
            last_acc = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_pushes(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 300) begin
            @(negedge clk); t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_write !== 1'b0 || req_addr !== 3'd0 || req_data !== '0 || pkt_sent !== 1'b0 ||
            err_trunc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got write=%b addr=%0d data=%h sent=%b trunc=%b busy=%b, required all 0",
                     req_write, req_addr, req_data, pkt_sent, err_trunc, busy);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
        obs_q.delete();
    endtask

    task automatic test_basic();
        int acc;
        beats.delete();
        beats.push_back(64'h11); beats.push_back(64'h22); beats.push_back(64'h33); beats.push_back(64'h44);
        occ[5] = 8'd0;
        obs_q.delete();
        send_packet(3'd5, 0, acc);
        wait_pushes(4);
        checks++;
        if (obs_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d pushes required 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                errors++; $display("FAIL basic_word%0d: missing, required %h", i, beats[i]);
            end else if (obs_q[i].addr !== 3'd5 || obs_q[i].data !== beats[i] || obs_q[i].sent !== (i == 3) ||
                         obs_q[i].cyc !== acc + 3 + i) begin
                errors++;
                $display("FAIL basic_word%0d: got q%0d %h sent=%b cyc=%0d, required q5 %h sent=%b cyc=%0d", i,
                         obs_q[i].addr, obs_q[i].data, obs_q[i].sent, obs_q[i].cyc, beats[i], (i == 3), acc + 3 + i);
            end
        end
    endtask

    task automatic test_random_packets();
        int acc, n;
        logic [2:0] q;
        for (int p = 0; p < 6; p++) begin
            q = 3'($urandom_range(0, 7));
            n = $urandom_range(1, BUFDEPTH);
            occ[q] = 8'($urandom_range(0, QDEPTH - n));
            make_beats(n);
            obs_q.delete();
            send_packet(q, 1, acc);
            wait_pushes(n);
            checks++;
            if (obs_q.size() != n) begin errors++; $display("FAIL rand%0d_count: got %0d required %0d", p, obs_q.size(), n); end
            for (int i = 0; i < n; i++) begin
                checks++;
                if (i >= obs_q.size()) begin
                    errors++; $display("FAIL rand%0d_word%0d: missing, required %h", p, i, beats[i]);
                end else if (obs_q[i].addr !== q || obs_q[i].data !== beats[i] || obs_q[i].sent !== (i == n - 1) ||
                             obs_q[i].cyc !== acc + 3 + i) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got q%0d %h sent=%b cyc=%0d, required q%0d %h sent=%b cyc=%0d", p, i,
                             obs_q[i].addr, obs_q[i].data, obs_q[i].sent, obs_q[i].cyc, q, beats[i], (i == n - 1), acc + 3 + i);
                end
            end
        end
    endtask

    task automatic test_full_packet();
        int acc;
        make_beats(BUFDEPTH);
        occ[7] = 8'd0;
        obs_q.delete();
        send_packet(3'd7, 0, acc);
        wait_pushes(BUFDEPTH);
        checks++;
        if (obs_q.size() != BUFDEPTH) begin errors++; $display("FAIL full_count: got %0d required %0d", obs_q.size(), BUFDEPTH); end
        for (int i = 0; i < BUFDEPTH; i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                errors++; $display("FAIL full_word%0d: missing, required %h", i, beats[i]);
            end else if (obs_q[i].addr !== 3'd7 || obs_q[i].data !== beats[i] || obs_q[i].sent !== (i == BUFDEPTH - 1) ||
                         obs_q[i].cyc !== acc + 3 + i) begin
                errors++;
                $display("FAIL full_word%0d: got q%0d %h sent=%b cyc=%0d, required q7 %h sent=%b cyc=%0d", i,
                         obs_q[i].addr, obs_q[i].data, obs_q[i].sent, obs_q[i].cyc, beats[i], (i == BUFDEPTH - 1), acc + 3 + i);
            end
        end
        checks++;
        if (err_trunc !== 1'b0) begin errors++; $display("FAIL full_no_trunc: got err_trunc=%b required 0", err_trunc); end
    endtask

    task automatic test_truncation();
        int acc;
        logic [DW-1:0] kept [$];
        make_beats(20);
        kept = beats[0:BUFDEPTH-1];
        occ[4] = 8'd0;
        obs_q.delete();
        send_packet(3'd4, 1, acc);
        wait_pushes(BUFDEPTH);
        checks++;
        if (obs_q.size() != BUFDEPTH) begin errors++; $display("FAIL trunc_count: got %0d required %0d", obs_q.size(), BUFDEPTH); end
        for (int i = 0; i < BUFDEPTH; i++) begin
            checks++;
            if (i >= obs_q.size()) begin
                errors++; $display("FAIL trunc_word%0d: missing, required %h", i, kept[i]);
            end else if (obs_q[i].addr !== 3'd4 || obs_q[i].data !== kept[i] || obs_q[i].sent !== (i == BUFDEPTH - 1) ||
                         obs_q[i].cyc !== acc + 3 + i) begin
                errors++;
                $display("FAIL trunc_word%0d: got q%0d %h sent=%b cyc=%0d, required q4 %h sent=%b cyc=%0d", i,
                         obs_q[i].addr, obs_q[i].data, obs_q[i].sent, obs_q[i].cyc, kept[i], (i == BUFDEPTH - 1), acc + 3 + i);
            end
        end
        checks++;
        if (err_trunc !== 1'b1) begin errors++; $display("FAIL trunc_flag: got err_trunc=%b required 1", err_trunc); end
        make_beats(2);
        occ[1] = 8'd10;
        obs_q.delete();
        send_packet(3'd1, 0, acc);
        wait_pushes(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i].addr !== 3'd1 || obs_q[i].data !== beats[i] || obs_q[i].cyc !== acc + 3 + i) begin
                errors++; $display("FAIL after_trunc_word%0d: got %0d pushes, required q1 %h at cyc %0d", i, obs_q.size(), beats[i], acc + 3 + i);
            end
        end
        checks++;
        if (err_trunc !== 1'b1) begin errors++; $display("FAIL trunc_sticky: got err_trunc=%b required 1", err_trunc); end
    endtask

    // Holds the packet in CHECK for exactly 5 cycles, then frees one slot.
    task automatic stall_packet(input string tag);
        int acc;
        make_beats(3);
        occ[2] = 8'd62;
        obs_q.delete();
        send_packet(3'd2, 0, acc);
        while (cyc < acc + 7) @(negedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s_hold: got pushes=%0d in_ready=%b busy=%b, required 0 0 1", tag, obs_q.size(), in_ready, busy);
        end
        occ[2] = 8'd61;
        wait_pushes(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i].addr !== 3'd2 || obs_q[i].data !== beats[i] || obs_q[i].cyc !== acc + 8 + i) begin
                errors++; $display("FAIL %s_word%0d: got %0d pushes, required q2 %h at cyc %0d", tag, i, obs_q.size(), beats[i], acc + 8 + i);
            end
        end
    endtask

    task automatic test_stall();
        int acc;
        stall_packet("stall");
        make_beats(1);
        occ[6] = 8'd200;
        obs_q.delete();
        send_packet(3'd6, 0, acc);
        while (cyc < acc + 8) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL overfull_hold: got %0d pushes required 0", obs_q.size()); end
        occ[6] = 8'd0;
        wait_pushes(1);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].data !== beats[0] || obs_q[0].cyc !== acc + 9) begin
            errors++; $display("FAIL overfull_release: got %0d pushes, required 1 push %h at cyc %0d", obs_q.size(), beats[0], acc + 9);
        end
    endtask

    task automatic test_reset_mid_push();
        int acc;
        make_beats(8);
        occ[3] = 8'd0;
        obs_q.delete();
        send_packet(3'd3, 0, acc);
        while (cyc < acc + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_write !== 1'b0 || req_addr !== 3'd0 || req_data !== '0 || pkt_sent !== 1'b0 ||
            err_trunc !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_values: got write=%b addr=%0d data=%h sent=%b trunc=%b in_ready=%b, required all 0",
                     req_write, req_addr, req_data, pkt_sent, err_trunc, in_ready);
        end
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL midrst_partial: got %0d pushes required 2", obs_q.size()); end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got busy=%b in_ready=%b required 0 1", busy, in_ready); end
        make_beats(1);
        occ[0] = 8'd0;
        obs_q.delete();
        @(negedge clk);
        send_packet(3'd0, 0, acc);
        wait_pushes(1);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].addr !== 3'd0 || obs_q[0].data !== beats[0] || obs_q[0].sent !== 1'b1 ||
            obs_q[0].cyc !== acc + 3) begin
            errors++; $display("FAIL midrst_next: got %0d pushes, required 1 push q0 %h sent=1 at cyc %0d", obs_q.size(), beats[0], acc + 3);
        end
    endtask

`ifdef ROUBUS_FEEDER_STATS_EN
    task automatic test_stats();
        int acc;
        do_reset();
        stall_packet("stats_stall");
        for (int p = 0; p < 2; p++) begin
            make_beats($urandom_range(1, 4));
            occ[1] = 8'd0;
            obs_q.delete();
            send_packet(3'd1, 0, acc);
            wait_pushes(beats.size());
        end
        checks++;
        if (pkt_total !== 32'd3) begin errors++; $display("FAIL stats_pkt_total: got %0d required 3", pkt_total); end
        checks++;
        if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_stall_cycles: got %0d required 5", stall_cycles); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_queue = '0; in_data = '0; in_last = 1'b0;
        for (int i = 0; i < 8; i++) occ[i] = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_random_packets();
        test_full_packet();
        test_truncation();
        test_stall();
        test_reset_mid_push();
`ifdef ROUBUS_FEEDER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
